status_buttons: RTL and testbench

- Front-panel input counterpart to the status LED driver: reads CHANNELS active-low push-buttons or switches and produces clean, debounced state and event strobes for the capture-control logic.
- Per channel:
  - 2-FF synchroniser
  - stability-counter debouncer
  - press/long-press state machine
  - sticky event flag with acknowledge handshake
- Sits between the DE0-Nano GPIO pins and the sampler control/USB status logic.

---
 rtl/status_buttons.sv | 185 ++++++++++++++++++
 tb/tb_status_buttons.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/status_buttons.sv
// Debounced front-panel button reader: per channel sync, debounce, press/long FSM, sticky event flag.
// Define STATUS_BUTTONS_REPEAT_EN to emit repeating longPulse strobes while a button stays held.
module status_buttons_ch #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000
`ifdef STATUS_BUTTONS_REPEAT_EN
  , parameter int REPEAT_CYCLES = 10000000
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic n_button,
  input  logic ack,
  output logic level,
  output logic press_pulse,
  output logic rel_pulse,
  output logic long_pulse,
  output logic pending
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef STATUS_BUTTONS_REPEAT_EN
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
`else
  localparam int HOLD_MAX = LONG_CYCLES;
`endif
  localparam int HW = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic          s1_q, s1_d, s2_q, s2_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          press_q, press_d, rel_q, rel_d, long_q, long_d, pend_q, pend_d;
  logic          accept;

  always_comb begin
    // inversion at the first flop so everything downstream is active-high
    s1_d      = ~n_button;
    s2_d      = s1_q;
    deb_cnt_d = '0;
    level_d   = level_q;
    accept    = 1'b0;
    if (s2_q != level_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        accept  = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    state_d = state_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (accept && level_d) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (accept) begin
          state_d = ST_RELEASED;
          rel_d   = 1'b1;
          hold_d  = '0;
        end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (accept) begin
          state_d = ST_RELEASED;
          rel_d   = 1'b1;
          hold_d  = '0;
        end else begin
`ifdef STATUS_BUTTONS_REPEAT_EN
          if (hold_q == HW'(REPEAT_CYCLES - 1)) begin
            long_d = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
`else
          hold_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_RELEASED;
        hold_d  = '0;
      end
    endcase

    // a new event beats a simultaneous acknowledge
    if (press_d || long_d) pend_d = 1'b1;
    else if (ack)          pend_d = 1'b0;
    else                   pend_d = pend_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      state_q   <= ST_RELEASED;
      hold_q    <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
      pend_q    <= pend_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = press_q;
  assign rel_pulse   = rel_q;
  assign long_pulse  = long_q;
  assign pending     = pend_q;
endmodule

module status_buttons #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] nButtons,
  input  logic [CHANNELS-1:0] eventAck,
  output logic [CHANNELS-1:0] buttonLevel,
  output logic [CHANNELS-1:0] pressPulse,
  output logic [CHANNELS-1:0] releasePulse,
  output logic [CHANNELS-1:0] longPulse,
  output logic [CHANNELS-1:0] eventPending
);
  localparam bit CFG_OK = (CHANNELS >= 1) && (CHANNELS <= 8) && (DEBOUNCE_CYCLES >= 1) &&
                          (LONG_CYCLES >= 1) && (REPEAT_CYCLES >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("status_buttons: parameter out of range");
  end

  status_buttons_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
`ifdef STATUS_BUTTONS_REPEAT_EN
    , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_ch [CHANNELS-1:0] (
    .clock      (clock),
    .reset      (reset),
    .n_button   (nButtons),
    .ack        (eventAck),
    .level      (buttonLevel),
    .press_pulse(pressPulse),
    .rel_pulse  (releasePulse),
    .long_pulse (longPulse),
    .pending    (eventPending)
  );
endmodule

// File: tb/tb_status_buttons.sv
// Scoreboard bench for status_buttons: stimulus queues expected pulse events, a negedge monitor checks them.
module tb_status_buttons;
  localparam int CH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] nButtons, eventAck;
  logic [CH-1:0] buttonLevel, pressPulse, releasePulse, longPulse, eventPending;

  status_buttons #(.CHANNELS(CH), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .nButtons(nButtons), .eventAck(eventAck),
    .buttonLevel(buttonLevel), .pressPulse(pressPulse), .releasePulse(releasePulse),
    .longPulse(longPulse), .eventPending(eventPending)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] press, rel, lng, lvl, pend;
  } ev_t;

  ev_t sb[$];
  ev_t r;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [CH-1:0] p, input logic [CH-1:0] rl,
                      input logic [CH-1:0] lg, input logic [CH-1:0] lv, input logic [CH-1:0] pe);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = rl; e.lng = lg; e.lvl = lv; e.pend = pe;
    sb.push_back(e);
  endtask

  // monitor: any strobe on any channel must match the head of the scoreboard
  always @(negedge clock) begin
    if (|(pressPulse | releasePulse | longPulse)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event at cycle %0d: press=%b rel=%b long=%b required none",
                 cyc, pressPulse, releasePulse, longPulse);
      end else begin
        r = sb.pop_front();
        chk("ev_cycle", cyc, r.cyc);
        chk("ev_press", 32'(pressPulse), 32'(r.press));
        chk("ev_release", 32'(releasePulse), 32'(r.rel));
        chk("ev_long", 32'(longPulse), 32'(r.lng));
        chk("ev_level", 32'(buttonLevel), 32'(r.lvl));
        chk("ev_pending", 32'(eventPending), 32'(r.pend));
      end
    end
  end

  int t0, t1;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ack_pulse(input int ch);
    eventAck[ch] = 1'b1;
    wait_neg(1);
    eventAck[ch] = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    nButtons = '1;
    eventAck = '0;
    wait_neg(3);
    chk("reset_outputs", 32'({buttonLevel, pressPulse, releasePulse, longPulse, eventPending}), 32'd0);
    reset = 1'b0;
    wait_neg(3);

    // clean press and release on channel 0
    nButtons[0] = 1'b0; t0 = cyc;
    push(t0 + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    wait_neg(12);
    nButtons[0] = 1'b1; t1 = cyc;
    push(t1 + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_neg(12);
    ack_pulse(0);
    chk("ack_ch0", 32'(eventPending), 32'd0);

    // bounce on channel 1 never reaches 8 stable cycles
    for (int k = 0; k < 50; k++) begin
      nButtons[1] = (((k / 3) % 2) == 0) ? 1'b0 : 1'b1;
      wait_neg(1);
      if ((k % 10) == 9) chk("bounce_level_pend", 32'({buttonLevel[1], eventPending[1]}), 32'd0);
    end
    nButtons[1] = 1'b1;
    wait_neg(12);
    chk("bounce_final", 32'({buttonLevel, eventPending}), 32'd0);

    // long press on channel 2
    nButtons[2] = 1'b0; t0 = cyc;
    push(t0 + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    push(t0 + 42, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
`ifdef STATUS_BUTTONS_REPEAT_EN
    push(t0 + 58, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
    push(t0 + 74, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
`endif
    wait_neg(70);
    nButtons[2] = 1'b1; t1 = cyc;
    push(t1 + 10, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    wait_neg(12);
    ack_pulse(2);
    chk("ack_ch2", 32'(eventPending), 32'd0);

    // ack handshake on channel 3
    nButtons[3] = 1'b0; t0 = cyc;
    push(t0 + 10, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    wait_neg(9);
    eventAck[3] = 1'b1;
    wait_neg(2);
    chk("ack_late_clears", 32'(eventPending[3]), 32'd0);
    eventAck[3] = 1'b0;
    wait_neg(1);
    ack_pulse(3);
    chk("ack_while_clear", 32'(eventPending[3]), 32'd0);
    nButtons[3] = 1'b1; t1 = cyc;
    push(t1 + 10, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    wait_neg(12);

    // reset in the middle of a debounce count with channel 0 held
    nButtons[0] = 1'b0;
    wait_neg(5);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_neg(1);
      chk("outputs_in_reset", 32'({buttonLevel, pressPulse, releasePulse, longPulse, eventPending}), 32'd0);
    end
    reset = 1'b0; t0 = cyc;
    push(t0 + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    wait_neg(12);
    nButtons[0] = 1'b1; t1 = cyc;
    push(t1 + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_neg(12);
    ack_pulse(0);
    chk("ack_ch0_after_reset", 32'(eventPending), 32'd0);

    // simultaneous press of channels 0 and 3
    nButtons = 4'b0110; t0 = cyc;
    push(t0 + 10, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b1001);
    wait_neg(12);
    nButtons = 4'b1111; t1 = cyc;
    push(t1 + 10, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    wait_neg(15);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
